mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS-subset CPU. It sequences the shared datapath (PC, IR, GRF, EXT, ALU, DM, NPC) through FETCH/DCD/EXE/MEM/WB states, one instruction at a time. It drives every write enable and mux select, including the 3-bit EXTOp into the immediate extender. It also keeps a retired-instruction counter for bench checking.

## Interface
Parameters:
- none (opcode/funct encodings fixed in Operation)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, sampled on the rising edge of clk
- op  in  6  IR[31:26]; stable from end of FETCH until next FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag, valid in EXE
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- RegWr  out  1  GRF write enable
- MemWr  out  1  DM write enable
- EXTOp  out  3  0 zero-ext, 1 sign-ext, 2 imm<<16, 3 sign-ext<<2; 4–7 never driven
- ALUOp  out  2  0 add, 1 sub, 2 or
- ALUSrc  out  1  0 rt data, 1 EXT output
- RegDst  out  2  0 rt, 1 rd, 2 $31
- WDSel  out  2  0 ALU, 1 DM, 2 PC
- NPCOp  out  2  0 PC+4, 1 branch, 2 j/jal target, 3 jr ($rs)
- state  out  3  0 FETCH, 1 DCD, 2 EXE, 3 MEM, 4 WB
- retired  out  32  count of completed instructions

## Operation
- Decode (combinational from op/funct):
  - addu: op 000000, funct 100001
  - subu: op 000000, funct 100011
  - jr: op 000000, funct 001000
  - nop: op 000000, funct 000000
  - ori: 001101
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - lui: 001111
  - j: 000010
  - jal: 000011
  - Anything else is illegal.
- Select signals (EXTOp, ALUOp, ALUSrc, RegDst, WDSel, NPCOp) are pure functions of the decoded class and are held constant from DCD to instruction end. In FETCH they output 0.
  - ori: EXTOp=0, ALUOp=or, ALUSrc=1, RegDst=rt
  - lw/sw: EXTOp=1, ALUOp=add, ALUSrc=1; lw also RegDst=rt, WDSel=DM
  - lui: EXTOp=2, ALUOp=add, ALUSrc=1, RegDst=rt
  - beq: EXTOp=3, ALUOp=sub, ALUSrc=0, NPCOp=branch
  - addu/subu: RegDst=rd, ALUSrc=0
  - jal: RegDst=$31, WDSel=PC, NPCOp=2
  - j: NPCOp=2
  - jr: NPCOp=3
- State machine:
  - FETCH: IRWr=1, PCWr=1 (NPCOp=0, PC<=PC+4) → DCD.
  - DCD:
    - j/jr: PCWr=1.
    - jal: PCWr=1, RegWr=1 (writes already-incremented PC to $31).
    - j/jal/jr, nop and illegal all → FETCH. Nop and illegal assert no enables.
    - All other classes → EXE.
  - EXE:
    - beq: PCWr=zero → FETCH.
    - lw/sw → MEM.
    - addu/subu/ori/lui → WB.
  - MEM:
    - sw: MemWr=1 → FETCH.
    - lw → WB.
  - WB: RegWr=1 → FETCH.
  - Encodings 5–7: no enables; the next state is FETCH.
- retired increments by 1 (mod 2^32, wraps silently) on every clock where the next state is FETCH and the current state is not FETCH. This includes nop, illegal and not-taken beq.

## Timing
- Cycles per instruction:
  - j/jal/jr/nop/illegal: 2
  - beq: 3
  - addu/subu/ori/lui/sw: 4
  - lw: 5
- Enables are Mealy outputs of state + decode (+zero in EXE). The datapath captures them at the rising edge that ends the state.
- Reset: on the edge with reset=1, state<=FETCH and retired<=0.
  - While reset=1, all enables (PCWr, IRWr, RegWr, MemWr) are forced to 0 and all selects to 0.
  - The first FETCH write occurs on the first edge after reset deasserts.
- Reset asserted mid-instruction (any state) aborts it with no further writes. retired is not incremented for the aborted instruction.
- zero is sampled only in EXE for beq and ignored elsewhere.
- op/funct changes outside FETCH are a datapath error. The controller re-decodes combinationally and does not latch them.

## Test plan
- Reset then ori (op 001101), held 4 cycles → state 0,1,2,4,0.
  - EXTOp=0, ALUSrc=1 from DCD onward.
  - RegWr=1 only in WB; retired=1.
- lw (100011) → five states 0,1,2,3,4; EXTOp=1; WDSel=1 and RegWr=1 in WB; MemWr never 1.
- sw (101011) → MemWr=1 exactly one cycle, in MEM; RegWr never 1; 4 cycles.
- beq with zero=1, then beq with zero=0 → EXTOp=3, NPCOp=1 throughout.
  - PCWr=1 in EXE only for the first beq.
  - retired advances by 2.
- jal then lui → jal asserts PCWr, RegWr, RegDst=2 and WDSel=2 in DCD, 2 cycles. lui then shows EXTOp=2 with RegWr in WB.
- Assert reset during lw MEM → next state FETCH, no RegWr, retired=0.
  - Separately, illegal op 111111 → 2 cycles, no enables, retired+1.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU.
// Walks each instruction through FETCH/DCD/EXE/MEM/WB and drives every
// datapath write enable and mux select. Also counts retired instructions.
//
//   state | meaning
//   FETCH | IR <= mem[PC], PC <= PC+4
//   DCD   | decode; jumps finish here (jal links $31)
//   EXE   | ALU operation; beq resolves the branch
//   MEM   | data memory access (lw read, sw write)
//   WB    | register file write-back
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic [2:0]  EXTOp,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic [1:0]  NPCOp,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI,
    C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL
  } cls_t;

  state_t cur, nxt;
  cls_t   cls;

  assign state = cur;

  // Instruction class, decoded straight from op/funct (never latched)
  always_comb begin
    cls = C_ILL;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001: cls = C_ADDU;
          6'b100011: cls = C_SUBU;
          6'b001000: cls = C_JR;
          6'b000000: cls = C_NOP;
          default:   cls = C_ILL;
        endcase
      end
      6'b001101: cls = C_ORI;
      6'b100011: cls = C_LW;
      6'b101011: cls = C_SW;
      6'b000100: cls = C_BEQ;
      6'b001111: cls = C_LUI;
      6'b000010: cls = C_J;
      6'b000011: cls = C_JAL;
      default:   cls = C_ILL;
    endcase
  end

  // Mux selects: a function of class only, zero in FETCH, unused states and reset
  always_comb begin
    EXTOp  = 3'd0;
    ALUOp  = 2'd0;
    ALUSrc = 1'b0;
    RegDst = 2'd0;
    WDSel  = 2'd0;
    NPCOp  = 2'd0;
    if (!reset && (cur == S_DCD || cur == S_EXE || cur == S_MEM || cur == S_WB)) begin
      case (cls)
        C_ORI:  begin ALUOp = 2'd2; ALUSrc = 1'b1; end
        C_LW:   begin EXTOp = 3'd1; ALUSrc = 1'b1; WDSel = 2'd1; end
        C_SW:   begin EXTOp = 3'd1; ALUSrc = 1'b1; end
        C_LUI:  begin EXTOp = 3'd2; ALUSrc = 1'b1; end
        C_BEQ:  begin EXTOp = 3'd3; ALUOp = 2'd1; NPCOp = 2'd1; end
        C_ADDU: RegDst = 2'd1;
        C_SUBU: begin RegDst = 2'd1; ALUOp = 2'd1; end
        C_JAL:  begin RegDst = 2'd2; WDSel = 2'd2; NPCOp = 2'd2; end
        C_J:    NPCOp = 2'd2;
        C_JR:   NPCOp = 2'd3;
        default: ;
      endcase
    end
  end

  // Mealy write enables and next-state selection
  always_comb begin
    PCWr  = 1'b0;
    IRWr  = 1'b0;
    RegWr = 1'b0;
    MemWr = 1'b0;
    nxt   = S_FETCH;
    case (cur)
      S_FETCH: begin
        PCWr = 1'b1;
        IRWr = 1'b1;
        nxt  = S_DCD;
      end
      S_DCD: begin
        case (cls)
          C_J, C_JR: PCWr = 1'b1;
          C_JAL: begin PCWr = 1'b1; RegWr = 1'b1; end
          default: ;
        endcase
        case (cls)
          C_J, C_JR, C_JAL, C_NOP, C_ILL: nxt = S_FETCH;
          default:                        nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        case (cls)
          C_BEQ: PCWr = zero;
          default: ;
        endcase
        case (cls)
          C_LW, C_SW:                nxt = S_MEM;
          C_ADDU, C_SUBU, C_ORI, C_LUI: nxt = S_WB;
          default:                   nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (cls == C_SW) MemWr = 1'b1;
        nxt = (cls == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        RegWr = 1'b1;
        nxt   = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
    if (reset) begin
      PCWr  = 1'b0;
      IRWr  = 1'b0;
      RegWr = 1'b0;
      MemWr = 1'b0;
    end
  end

  // State register and retired counter; an instruction retires when it leaves for FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_FETCH;
      retired <= 32'd0;
    end else begin
      cur <= nxt;
      if (nxt == S_FETCH && cur != S_FETCH)
        retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios then random instruction
// streams, compared cycle by cycle against a per-instruction reference table.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero;
  logic        PCWr, IRWr, RegWr, MemWr;
  logic [2:0]  EXTOp;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic [1:0]  RegDst, WDSel, NPCOp;
  logic [2:0]  state;
  logic [31:0] retired;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .WDSel(WDSel), .NPCOp(NPCOp), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] retired_m = 0;

  // enable mask bits: 0 PCWr, 1 IRWr, 2 RegWr, 3 MemWr, 4 PCWr-when-zero
  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    bit         anyf;     // funct is don't-care
    int         n;        // cycles per instruction
    bit         mem;      // passes through MEM
    logic [4:0] dcd_en;
    logic [4:0] last_en;  // enables of the final cycle when it is after DCD
    logic [2:0] ext;
    logic [1:0] alu;
    logic       src;
    logic [1:0] rdst;
    logic [1:0] wd;
    logic [1:0] npc;
  } instr_t;

  localparam int I_ADDU = 0, I_SUBU = 1, I_JR = 2, I_NOP = 3, I_ORI = 4, I_LW = 5,
                 I_SW = 6, I_BEQ = 7, I_LUI = 8, I_J = 9, I_JAL = 10, I_ILL = 11,
                 I_ILL0 = 12;

  function automatic instr_t entry(input int idx);
    instr_t t = '{op: 6'd0, funct: 6'd0, anyf: 1'b1, n: 2, mem: 1'b0,
                  dcd_en: 5'd0, last_en: 5'd0, ext: 3'd0, alu: 2'd0,
                  src: 1'b0, rdst: 2'd0, wd: 2'd0, npc: 2'd0};
    case (idx)
      I_ADDU: begin t.funct = 6'h21; t.anyf = 0; t.n = 4; t.last_en = 5'h4; t.rdst = 1; end
      I_SUBU: begin t.funct = 6'h23; t.anyf = 0; t.n = 4; t.last_en = 5'h4; t.rdst = 1; t.alu = 1; end
      I_JR:   begin t.funct = 6'h08; t.anyf = 0; t.dcd_en = 5'h1; t.npc = 3; end
      I_NOP:  begin t.funct = 6'h00; t.anyf = 0; end
      I_ORI:  begin t.op = 6'h0d; t.n = 4; t.last_en = 5'h4; t.alu = 2; t.src = 1; end
      I_LW:   begin t.op = 6'h23; t.n = 5; t.mem = 1; t.last_en = 5'h4; t.ext = 1; t.src = 1; t.wd = 1; end
      I_SW:   begin t.op = 6'h2b; t.n = 4; t.mem = 1; t.last_en = 5'h8; t.ext = 1; t.src = 1; end
      I_BEQ:  begin t.op = 6'h04; t.n = 3; t.last_en = 5'h10; t.ext = 3; t.alu = 1; t.npc = 1; end
      I_LUI:  begin t.op = 6'h0f; t.n = 4; t.last_en = 5'h4; t.ext = 2; t.src = 1; end
      I_J:    begin t.op = 6'h02; t.dcd_en = 5'h1; t.npc = 2; end
      I_JAL:  begin t.op = 6'h03; t.dcd_en = 5'h5; t.rdst = 2; t.wd = 2; t.npc = 2; end
      I_ILL:  begin t.op = 6'h3f; end
      default: begin t.funct = 6'h2a; t.anyf = 0; end
    endcase
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Runs one instruction; abort_at >= 0 asserts reset during that cycle
  task automatic run(input int idx, input int zforce, input int abort_at);
    instr_t t;
    logic [4:0] m;
    logic z, on;
    logic [2:0] st;
    t = entry(idx);
    op = t.op;
    funct = t.anyf ? 6'($urandom) : t.funct;
    for (int s = 0; s < t.n; s++) begin
      z = (zforce < 0) ? 1'($urandom) : 1'(zforce);
      zero = z;
      if (s == 0)               m = 5'h3;
      else if (s == 1)          m = t.dcd_en;
      else if (s == t.n - 1)    m = t.last_en;
      else                      m = 5'h0;
      if (s == 0)      st = 3'd0;
      else if (s == 1) st = 3'd1;
      else if (s == 2) st = 3'd2;
      else if (s == 3) st = t.mem ? 3'd3 : 3'd4;
      else             st = 3'd4;
      on = (s != 0);
      if (s == abort_at) begin
        reset = 1'b1;
        m = 5'h0;
        on = 1'b0;
      end
      @(negedge clk);
      check("state",   32'(state),   32'(st));
      check("PCWr",    32'(PCWr),    32'(m[0] | (m[4] & z)));
      check("IRWr",    32'(IRWr),    32'(m[1]));
      check("RegWr",   32'(RegWr),   32'(m[2]));
      check("MemWr",   32'(MemWr),   32'(m[3]));
      check("EXTOp",   32'(EXTOp),   on ? 32'(t.ext)  : 32'd0);
      check("ALUOp",   32'(ALUOp),   on ? 32'(t.alu)  : 32'd0);
      check("ALUSrc",  32'(ALUSrc),  on ? 32'(t.src)  : 32'd0);
      check("RegDst",  32'(RegDst),  on ? 32'(t.rdst) : 32'd0);
      check("WDSel",   32'(WDSel),   on ? 32'(t.wd)   : 32'd0);
      check("NPCOp",   32'(NPCOp),   on ? 32'(t.npc)  : 32'd0);
      check("retired", retired, retired_m);
      @(posedge clk);
      #1;
      if (s == abort_at) begin
        reset = 1'b0;
        retired_m = 32'd0;
        return;
      end
    end
    retired_m = retired_m + 32'd1;
  endtask

  initial begin
    int idx, ab;
    reset = 1'b1;
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_PCWr", 32'(PCWr), 32'd0);
    check("rst_IRWr", 32'(IRWr), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(I_ORI, -1, -1);
    run(I_LW, -1, -1);
    run(I_SW, -1, -1);
    run(I_BEQ, 1, -1);
    run(I_BEQ, 0, -1);
    run(I_JAL, -1, -1);
    run(I_LUI, -1, -1);
    run(I_LW, -1, 3);
    run(I_ILL, -1, -1);
    run(I_ILL0, -1, -1);
    run(I_NOP, -1, -1);
    run(I_J, -1, -1);
    run(I_JR, -1, -1);
    run(I_ADDU, -1, -1);
    run(I_SUBU, -1, -1);

    for (int k = 0; k < 400; k++) begin
      idx = int'($urandom_range(0, 12));
      ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1;
      run(idx, -1, ab);
    end

    @(negedge clk);
    check("final_retired", retired, retired_m);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
